// File: rtl/program_loader_if.sv
// Host byte-stream link into the program loader: valid/ready handshake, one byte per transfer.
// The host side drives valid/data; the loader returns ready.
interface program_loader_if;
   logic       in_valid;
   logic [7:0] in_data;
   logic       in_ready;

   modport master (
      output in_valid,
      output in_data,
      input  in_ready
   );

   modport slave (
      input  in_valid,
      input  in_data,
      output in_ready
   );
endinterface

// File: rtl/program_loader.sv
// Boot-time program loader for the riscv32 core.
// Takes a little-endian byte stream (word count N, then N words) from the host link, writes the
// words to consecutive memory locations starting at BASE_ADDR and keeps the core in reset until
// a complete, well-formed image has been written.
// Optional feature: define PROGRAM_LOADER_CHECKSUM_EN to require a trailing 4-byte checksum
// (mod-2^32 sum of all data words) before the core is released.
module program_loader #(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int unsigned MAX_WORDS = 1024
) (
   input  logic              clk,
   input  logic              reset,
   program_loader_if.slave   host,
   output logic              mem_we,
   output logic [31:0]       mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              cpu_reset,
   output logic              load_done,
   output logic              load_err,
   output logic [31:0]       words_loaded
);

   localparam logic [2:0] ST_LEN  = 3'd0;
   localparam logic [2:0] ST_DATA = 3'd1;
   localparam logic [2:0] ST_CHK  = 3'd2;
   localparam logic [2:0] ST_DONE = 3'd3;
   localparam logic [2:0] ST_ERR  = 3'd4;

   logic [2:0]  state_q;
   logic [1:0]  lane_q;
   // Only the three most recent bytes need to be kept; the fourth arrives on the bus.
   logic [23:0] asm_q;
   logic [31:0] len_q;
   logic [31:0] words_q;
   logic        mem_we_q;
   logic [31:0] mem_addr_q;
   logic [31:0] mem_wdata_q;
   logic        cpu_reset_q;
   logic        done_q;
   logic        err_q;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
   logic [31:0] sum_q;
`endif

   logic        accepting;
   logic        fire;
   logic        last_byte;
   logic [31:0] word;

   // Handshake and the word completed by the byte currently on the bus.
   always_comb begin
      accepting     = (state_q == ST_LEN) || (state_q == ST_DATA) || (state_q == ST_CHK);
      host.in_ready = accepting && !reset;
      fire          = host.in_valid && host.in_ready;
      last_byte     = fire && (lane_q == 2'd3);
      word          = {host.in_data, asm_q};
   end

   // Framing state machine, byte assembly and memory write generation.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_LEN;
         lane_q      <= 2'd0;
         asm_q       <= 24'd0;
         len_q       <= 32'd0;
         words_q     <= 32'd0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= BASE_ADDR;
         mem_wdata_q <= 32'd0;
         cpu_reset_q <= 1'b1;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
         sum_q       <= 32'd0;
`endif
      end else begin
         mem_we_q <= 1'b0;
         if (fire) begin
            lane_q <= lane_q + 2'd1;
            asm_q  <= word[31:8];
         end
         case (state_q)
            ST_LEN: begin
               if (last_byte) begin
                  len_q <= word;
                  if (word == 32'd0) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                     state_q <= ST_CHK;
`else
                     // No write to wait for: release on the next cycle.
                     state_q     <= ST_DONE;
                     cpu_reset_q <= 1'b0;
                     done_q      <= 1'b1;
`endif
                  end else if (word > 32'(MAX_WORDS)) begin
                     state_q <= ST_ERR;
                     err_q   <= 1'b1;
                  end else begin
                     state_q <= ST_DATA;
                  end
               end
            end
            ST_DATA: begin
               if (last_byte) begin
                  mem_we_q    <= 1'b1;
                  mem_addr_q  <= BASE_ADDR + {words_q[29:0], 2'b00};
                  mem_wdata_q <= word;
                  words_q     <= words_q + 32'd1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                  sum_q       <= sum_q + word;
`endif
                  if (words_q == len_q - 32'd1) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                     state_q <= ST_CHK;
`else
                     // Release follows from ST_DONE, one cycle after this write.
                     state_q <= ST_DONE;
`endif
                  end
               end
            end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            ST_CHK: begin
               if (last_byte) begin
                  if (word == sum_q) begin
                     state_q     <= ST_DONE;
                     cpu_reset_q <= 1'b0;
                     done_q      <= 1'b1;
                  end else begin
                     state_q <= ST_ERR;
                     err_q   <= 1'b1;
                  end
               end
            end
`endif
            ST_DONE: begin
               cpu_reset_q <= 1'b0;
               done_q      <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Registered outputs.
   always_comb begin
      mem_we       = mem_we_q;
      mem_addr     = mem_addr_q;
      mem_wdata    = mem_wdata_q;
      cpu_reset    = cpu_reset_q;
      load_done    = done_q;
      load_err     = err_q;
      words_loaded = words_q;
   end

endmodule

// File: tb/tb_program_loader.sv
// Directed self-checking bench for program_loader (default build; checksum steps are enabled
// when PROGRAM_LOADER_CHECKSUM_EN is defined).
module tb_program_loader;

   logic        clk = 1'b0;
   logic        reset;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        cpu_reset;
   logic        load_done;
   logic        load_err;
   logic [31:0] words_loaded;

   int vectors = 0;
   int miscompares = 0;

   logic [31:0] wr_addr[$];
   logic [31:0] wr_data[$];

   logic [31:0] img[3];
   int          base;

   program_loader_if bus ();

   program_loader #(
      .BASE_ADDR (32'h0000_0000),
      .MAX_WORDS (1024)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .host         (bus.slave),
      .mem_we       (mem_we),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .cpu_reset    (cpu_reset),
      .load_done    (load_done),
      .load_err     (load_err),
      .words_loaded (words_loaded)
   );

   always #5 clk = ~clk;

   // Log every memory write, sampled mid-cycle.
   always @(negedge clk) begin
      if (mem_we === 1'b1) begin
         wr_addr.push_back(mem_addr);
         wr_data.push_back(mem_wdata);
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic do_reset(input int n);
      @(negedge clk);
      reset = 1'b1;
      bus.in_valid = 1'b0;
      repeat (n) @(posedge clk);
      #1 chk("ready_low_in_reset", 32'(bus.in_ready), 32'd0);
      @(negedge clk);
      reset = 1'b0;
   endtask

   // Present one byte after 'gap' idle cycles; returns 1 time unit after the accepting edge.
   task automatic send_byte(input logic [7:0] b, input int gap);
      int tries;
      tries = 0;
      repeat (gap) @(negedge clk);
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = b;
      while (bus.in_ready !== 1'b1 && tries < 16) begin
         @(negedge clk);
         tries++;
      end
      if (tries >= 16) chk("in_ready_timeout", 32'(bus.in_ready), 32'd1);
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w, input int maxgap);
      for (int i = 0; i < 4; i++) begin
         send_byte(w[8*i +: 8], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
      end
   endtask

   task automatic check_image(input string tag);
      chk({tag, "_wr_count"}, 32'(wr_addr.size() - base), 32'd3);
      for (int k = 0; k < 3; k++) begin
         if (wr_addr.size() > base + k) begin
            chk({tag, "_addr"}, wr_addr[base + k], 32'(4 * k));
            chk({tag, "_data"}, wr_data[base + k], img[k]);
         end
      end
   endtask

   initial begin
      img[0] = 32'h0000_0513;
      img[1] = 32'h0010_0593;
      img[2] = 32'h00B5_0533;
      reset = 1'b1;
      bus.in_valid = 1'b0;
      bus.in_data = 8'h00;

      // Reset state.
      do_reset(2);
      #1;
      chk("rst_cpu_reset", 32'(cpu_reset), 32'd1);
      chk("rst_load_done", 32'(load_done), 32'd0);
      chk("rst_load_err", 32'(load_err), 32'd0);
      chk("rst_mem_we", 32'(mem_we), 32'd0);
      chk("rst_mem_addr", mem_addr, 32'h0);
      chk("rst_mem_wdata", mem_wdata, 32'h0);
      chk("rst_words", words_loaded, 32'd0);
      chk("rst_in_ready", 32'(bus.in_ready), 32'd1);

      // Nominal: N = 3, full-rate bytes.
      base = wr_addr.size();
      send_word(32'd3, 0);
      send_word(img[0], 0);
      send_word(img[1], 0);
      send_word(img[2], 0);
      chk("nom_we_last", 32'(mem_we), 32'd1);
      chk("nom_addr_last", mem_addr, 32'h8);
      chk("nom_data_last", mem_wdata, img[2]);
      chk("nom_words_with_we", words_loaded, 32'd3);
      chk("nom_cpu_reset_held", 32'(cpu_reset), 32'd1);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      chk("nom_ready_chk", 32'(bus.in_ready), 32'd1);
      send_word(32'h00C5_0FD9, 0);
      chk("nom_cpu_reset_rel", 32'(cpu_reset), 32'd0);
      chk("nom_done", 32'(load_done), 32'd1);
`else
      chk("nom_ready_low", 32'(bus.in_ready), 32'd0);
      chk("nom_done_not_yet", 32'(load_done), 32'd0);
      @(posedge clk);
      #1;
      chk("nom_we_pulse_end", 32'(mem_we), 32'd0);
      chk("nom_cpu_reset_rel", 32'(cpu_reset), 32'd0);
      chk("nom_done", 32'(load_done), 32'd1);
      chk("nom_addr_hold", mem_addr, 32'h8);
      chk("nom_data_hold", mem_wdata, img[2]);
`endif
      // Input is ignored once done.
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = 8'hAA;
      repeat (6) @(negedge clk);
      bus.in_valid = 1'b0;
      chk("nom_words_final", words_loaded, 32'd3);
      check_image("nom");

      // Throttled host with random gaps; no write before a word's 4th byte.
      do_reset(1);
      base = wr_addr.size();
      send_word(32'd3, 5);
      for (int k = 0; k < 3; k++) begin
         for (int i = 0; i < 3; i++) send_byte(img[k][8*i +: 8], int'($urandom_range(0, 5)));
         repeat (2) @(negedge clk);
         chk("thr_no_early_we", 32'(wr_addr.size() - base), 32'(k));
         send_byte(img[k][31:24], int'($urandom_range(0, 5)));
      end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      send_word(32'h00C5_0FD9, 5);
`endif
      repeat (3) @(negedge clk);
      chk("thr_done", 32'(load_done), 32'd1);
      chk("thr_cpu_reset", 32'(cpu_reset), 32'd0);
      check_image("thr");

      // Empty image.
      do_reset(1);
      base = wr_addr.size();
      send_word(32'd0, 0);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      chk("empty_cpu_reset_held", 32'(cpu_reset), 32'd1);
      send_word(32'd0, 0);
`endif
      chk("empty_cpu_reset", 32'(cpu_reset), 32'd0);
      chk("empty_done", 32'(load_done), 32'd1);
      chk("empty_ready", 32'(bus.in_ready), 32'd0);
      repeat (3) @(negedge clk);
      chk("empty_no_we", 32'(wr_addr.size() - base), 32'd0);

      // Oversized image: N = MAX_WORDS + 1.
      do_reset(1);
      base = wr_addr.size();
      send_word(32'd1025, 0);
      chk("big_err", 32'(load_err), 32'd1);
      chk("big_ready", 32'(bus.in_ready), 32'd0);
      repeat (3) @(negedge clk);
      chk("big_cpu_reset", 32'(cpu_reset), 32'd1);
      chk("big_done", 32'(load_done), 32'd0);
      chk("big_no_we", 32'(wr_addr.size() - base), 32'd0);

      // Reset mid-word, then a full reload.
      do_reset(1);
      base = wr_addr.size();
      send_word(32'd2, 0);
      send_word(img[0], 0);
      send_byte(img[1][7:0], 0);
      send_byte(img[1][15:8], 0);
      @(negedge clk);
      chk("mid_one_write", 32'(wr_addr.size() - base), 32'd1);
      if (wr_addr.size() > base) chk("mid_addr", wr_addr[base], 32'h0);
      do_reset(1);
      #1;
      chk("mid_words_cleared", words_loaded, 32'd0);
      chk("mid_cpu_reset", 32'(cpu_reset), 32'd1);
      chk("mid_we", 32'(mem_we), 32'd0);
      repeat (3) @(negedge clk);
      chk("mid_no_partial_write", 32'(wr_addr.size() - base), 32'd1);
      base = wr_addr.size();
      send_word(32'd3, 0);
      for (int k = 0; k < 3; k++) send_word(img[k], 0);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      send_word(32'h00C5_0FD9, 0);
`endif
      repeat (2) @(negedge clk);
      chk("reload_done", 32'(load_done), 32'd1);
      chk("reload_words", words_loaded, 32'd3);
      check_image("reload");

`ifdef PROGRAM_LOADER_CHECKSUM_EN
      // Checksum good: wraps to 1.
      do_reset(1);
      send_word(32'd2, 0);
      send_word(32'hFFFF_FFFF, 0);
      send_word(32'h0000_0002, 0);
      send_word(32'h0000_0001, 0);
      chk("cs_good_done", 32'(load_done), 32'd1);
      chk("cs_good_cpu_reset", 32'(cpu_reset), 32'd0);
      // Checksum bad.
      do_reset(1);
      send_word(32'd2, 0);
      send_word(32'hFFFF_FFFF, 0);
      send_word(32'h0000_0002, 0);
      send_word(32'h0000_0002, 0);
      repeat (2) @(negedge clk);
      chk("cs_bad_err", 32'(load_err), 32'd1);
      chk("cs_bad_cpu_reset", 32'(cpu_reset), 32'd1);
      chk("cs_bad_done", 32'(load_done), 32'd0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: bench did not finish, %0d vectors applied", vectors);
      $fatal(1, "watchdog expired");
   end

endmodule
